bsg_fpu_f2i: RTL and testbench

BSG_FPU_F2I -- requirements
Module: bsg_fpu_f2i

---
 rtl/bsg_fpu_f2i.sv | 176 +++++++++++++++++
 tb/tb_bsg_fpu_f2i.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fpu_f2i.sv
// bsg_fpu_f2i: two-stage float-to-integer converter with valid/ready/yumi flow control.
// Stage 1 registers the decoded input fields; stage 2 registers the saturated integer result.
// Rounding is toward zero by default. Defining BSG_FPU_F2I_RNE_EN selects
// round-to-nearest-even, with the same interface and latency.
`timescale 1ns/1ps
module bsg_fpu_f2i #(
    parameter e_p = "inv",
    parameter m_p = "inv"
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               v_i,
    input  logic               signed_i,
    input  logic [e_p+m_p:0]   a_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [e_p+m_p:0]   z_o,
    output logic               invalid_o,
    input  logic               yumi_i
);
    localparam int W   = e_p + m_p + 1;
    localparam int XW  = W + m_p;
    localparam int SHW = $clog2(W);

    localparam logic [e_p:0] BIAS    = {2'b00, {(e_p-1){1'b1}}};
    localparam logic [W:0]   POS_LIM = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0]   NEG_LIM = {2'b01, {(W-1){1'b0}}};
    localparam logic [W:0]   U_LIM   = {1'b0, {W{1'b1}}};
    localparam logic [W-1:0] POS_SAT = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_SAT = {1'b1, {(W-1){1'b0}}};

    // Both stages advance together; a held result blocks the whole pipe.
    logic advance;
    logic v2_reg;
    assign ready_o = en_i & ~(v2_reg & ~yumi_i);
    assign advance = ready_o;

    // Input field decode.
    logic             a_sign;
    logic [e_p-1:0]   a_exp;
    logic [m_p-1:0]   a_man;
    assign a_sign = a_i[W-1];
    assign a_exp  = a_i[W-2 -: e_p];
    assign a_man  = a_i[m_p-1:0];

    // Stage 1 state.
    logic                v1_reg;
    logic                sign_reg;
    logic signed [e_p:0] exp_reg;
    logic [m_p:0]        man_reg;
    logic                zero_reg;
    logic                inf_reg;
    logic                nan_reg;
    logic                signed_reg;

    // Stage 1 valid: cleared by reset, otherwise follows v_i on each advance.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            v1_reg <= 1'b0;
        else if (advance)
            v1_reg <= v_i;
    end

    // Stage 1 data: loaded only when a valid input is accepted.
    always_ff @(posedge clk_i) begin
        if (advance && v_i) begin
            sign_reg   <= a_sign;
            exp_reg    <= $signed({1'b0, a_exp}) - $signed(BIAS);
            man_reg    <= {1'b1, a_man};
            zero_reg   <= (a_exp == '0);
            inf_reg    <= (&a_exp) && (a_man == '0);
            nan_reg    <= (&a_exp) && (a_man != '0);
            signed_reg <= signed_i;
        end
    end

    // Magnitude, rounding and range check between stage 1 and stage 2.
    logic signed [31:0] e_ext;
    logic               e_neg;
    logic               e_big;
    logic [XW-1:0]      ext;
    logic [W-1:0]       mag_trunc;
    logic [W:0]         mag;
    logic [W-1:0]       z_next;
    logic               inv_next;
`ifdef BSG_FPU_F2I_RNE_EN
    logic               guard;
    logic               sticky;
    logic               round_up;
`endif

    // Compute the integer result for the stage 1 contents.
    always_comb begin
        e_ext     = 32'(exp_reg);
        e_neg     = (e_ext < 0);
        e_big     = (e_ext >= W);
        ext       = {{(W-1){1'b0}}, man_reg} << e_ext[SHW-1:0];
        mag_trunc = e_neg ? '0 : W'(ext >> m_p);
`ifdef BSG_FPU_F2I_RNE_EN
        // Below one, only E = -1 (value in [0.5,1)) can round up.
        guard    = e_neg ? (e_ext == -1) : ext[m_p-1];
        sticky   = e_neg ? ((e_ext == -1) && (man_reg[m_p-1:0] != '0))
                         : (ext[m_p-2:0] != '0);
        round_up = guard & (sticky | mag_trunc[0]);
        mag      = {1'b0, mag_trunc} + (W+1)'(round_up);
`else
        mag      = {1'b0, mag_trunc};
`endif
        z_next   = '0;
        inv_next = 1'b0;
        if (nan_reg) begin
            z_next   = signed_reg ? POS_SAT : '1;
            inv_next = 1'b1;
        end else if (inf_reg) begin
            if (!sign_reg)
                z_next = signed_reg ? POS_SAT : '1;
            else
                z_next = signed_reg ? NEG_SAT : '0;
            inv_next = 1'b1;
        end else if (zero_reg) begin
            z_next   = '0;
            inv_next = 1'b0;
        end else if (signed_reg) begin
            if (!sign_reg) begin
                if (e_big || (mag > POS_LIM)) begin
                    z_next   = POS_SAT;
                    inv_next = 1'b1;
                end else begin
                    z_next = mag[W-1:0];
                end
            end else begin
                if (e_big || (mag > NEG_LIM)) begin
                    z_next   = NEG_SAT;
                    inv_next = 1'b1;
                end else begin
                    z_next = -mag[W-1:0];
                end
            end
        end else begin
            if (sign_reg) begin
                // Negative to unsigned: only a value that rounds to zero is valid.
                z_next   = '0;
                inv_next = e_big || (mag != '0);
            end else if (e_big || (mag > U_LIM)) begin
                z_next   = '1;
                inv_next = 1'b1;
            end else begin
                z_next = mag[W-1:0];
            end
        end
    end

    // Stage 2 state.
    logic [W-1:0] z_reg;
    logic         inv_reg;

    // Stage 2: valid follows stage 1 on advance; data loads only for valid entries.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v2_reg  <= 1'b0;
            z_reg   <= '0;
            inv_reg <= 1'b0;
        end else if (advance) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                z_reg   <= z_next;
                inv_reg <= inv_next;
            end
        end
    end

    assign v_o       = v2_reg;
    assign z_o       = z_reg;
    assign invalid_o = inv_reg;
endmodule

// File: tb/tb_bsg_fpu_f2i.sv
// Testbench for bsg_fpu_f2i (e_p=8, m_p=23): directed and random stimulus,
// scoreboard queue filled on acceptance, monitor pops on each consumed output.
`timescale 1ns/1ps
module tb_bsg_fpu_f2i;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        en_i;
    logic        v_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic        ready_o;
    logic        v_o;
    logic [31:0] z_o;
    logic        invalid_o;
    logic        yumi_i;

    bsg_fpu_f2i #(.e_p(8), .m_p(23)) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .en_i     (en_i),
        .v_i      (v_i),
        .signed_i (signed_i),
        .a_i      (a_i),
        .ready_o  (ready_o),
        .v_o      (v_o),
        .z_o      (z_o),
        .invalid_o(invalid_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic        sg;
        logic [31:0] z;
        logic        inv;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   yumi_mode = 0;   // 0: take every output, 1: random, 2: hold off

    // Reference: value = 1.man * 2^(exp-127), rounded then range-limited.
    function automatic void model(input logic [31:0] a, input logic sg,
                                  output logic [31:0] z, output logic inv);
        logic s;
        int ex, e, sh;
        longint unsigned sig, mag;
`ifdef BSG_FPU_F2I_RNE_EN
        longint unsigned rem, half;
`endif
        s   = a[31];
        ex  = int'(a[30:23]);
        sig = 64'h80_0000 | 64'(a[22:0]);
        z   = 32'd0;
        inv = 1'b0;
        if (ex == 255) begin
            inv = 1'b1;
            if (a[22:0] != 0 || !s) z = sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            else                    z = sg ? 32'h8000_0000 : 32'h0;
            return;
        end
        if (ex == 0) return;
        e = ex - 127;
        if (e > 40) mag = 64'd1 << 50;
        else if (e >= 23) mag = sig << (e - 23);
        else begin
            sh = 23 - e;
            if (sh > 60) mag = 0;
            else begin
                mag = sig >> sh;
`ifdef BSG_FPU_F2I_RNE_EN
                rem  = sig - (mag << sh);
                half = 64'd1 << (sh - 1);
                if (rem > half || (rem == half && mag[0])) mag = mag + 1;
`endif
            end
        end
        if (sg) begin
            if (!s) begin
                if (mag > 64'h7FFF_FFFF) begin z = 32'h7FFF_FFFF; inv = 1'b1; end
                else z = mag[31:0];
            end else begin
                if (mag > 64'h8000_0000) begin z = 32'h8000_0000; inv = 1'b1; end
                else z = 32'(64'd0 - mag);
            end
        end else begin
            if (s) begin z = 32'h0; inv = (mag != 0); end
            else if (mag > 64'hFFFF_FFFF) begin z = 32'hFFFF_FFFF; inv = 1'b1; end
            else z = mag[31:0];
        end
    endfunction

    // Consumer: decides yumi_i shortly after each edge, once v_o has settled.
    initial begin
        yumi_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (yumi_mode)
                0:       yumi_i = v_o;
                1:       yumi_i = v_o & ($urandom_range(0, 1) == 1);
                default: yumi_i = 1'b0;
            endcase
        end
    end

    // Monitor: every consumed output is compared against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_i && v_o && yumi_i) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output z=%h inv=%b (no result outstanding)", z_o, invalid_o);
            end else begin
                e = sb.pop_front();
                if (z_o !== e.z || invalid_o !== e.inv) begin
                    failures++;
                    $display("FAIL result a=%h signed=%b got z=%h inv=%b expected z=%h inv=%b",
                             e.a, e.sg, z_o, invalid_o, e.z, e.inv);
                end else begin
                    $display("ok a=%h signed=%b z=%h inv=%b", e.a, e.sg, z_o, invalid_o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // Present one input and hold it until accepted; push the expectation on acceptance.
    task automatic send(input logic [31:0] a, input logic sg, input logic [31:0] z, input logic inv);
        bit done;
        done     = 0;
        a_i      = a;
        signed_i = sg;
        v_i      = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (ready_o) begin
                sb.push_back('{a, sg, z, inv});
                done = 1;
            end
            tick();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout a=%h never accepted", a);
        end
    endtask

    task automatic send_model(input logic [31:0] a, input logic sg);
        logic [31:0] z;
        logic        inv;
        model(a, sg, z, inv);
        send(a, sg, z, inv);
    endtask

    task automatic drain();
        v_i = 1'b0;
        for (int k = 0; k < 500 && sb.size() != 0; k++) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout outstanding=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int acc;
        logic [31:0] a;
        reset_i  = 1'b1;
        en_i     = 1'b1;
        v_i      = 1'b0;
        signed_i = 1'b0;
        a_i      = 32'h0;
        repeat (3) tick();
        reset_i = 1'b0;
        check("reset_v_o", 32'(v_o), 32'd0);
        check("reset_z_o", z_o, 32'd0);
        check("reset_invalid_o", 32'(invalid_o), 32'd0);
        check("reset_ready_o", 32'(ready_o), 32'd1);

        en_i = 1'b0;
        #1;
        check("enable_low_ready_o", 32'(ready_o), 32'd0);
        en_i = 1'b1;
        tick();

        // Latency: result valid exactly two advancing edges after acceptance.
        send(32'h40490FDB, 1'b1, 32'h0000_0003, 1'b0);
        v_i = 1'b0;
        check("latency_v_o_after_1", 32'(v_o), 32'd0);
        tick();
        check("latency_v_o_after_2", 32'(v_o), 32'd1);
        drain();

        // Directed values.
`ifdef BSG_FPU_F2I_RNE_EN
        send(32'hC0700000, 1'b1, 32'hFFFF_FFFC, 1'b0);
        send(32'h3FC00000, 1'b1, 32'h0000_0002, 1'b0);
`else
        send(32'hC0700000, 1'b1, 32'hFFFF_FFFD, 1'b0);
        send(32'h3FC00000, 1'b1, 32'h0000_0001, 1'b0);
`endif
        send(32'h40200000, 1'b1, 32'h0000_0002, 1'b0);
        send(32'h4F000000, 1'b1, 32'h7FFF_FFFF, 1'b1);
        send(32'h4F000000, 1'b0, 32'h8000_0000, 1'b0);
        send(32'hCF000000, 1'b1, 32'h8000_0000, 1'b0);
        send(32'h7FC00000, 1'b1, 32'h7FFF_FFFF, 1'b1);
        send(32'h7FC00000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send(32'hFF800000, 1'b0, 32'h0000_0000, 1'b1);
        send(32'hFF800000, 1'b1, 32'h8000_0000, 1'b1);
        send(32'h7F800000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send(32'h7F800000, 1'b1, 32'h7FFF_FFFF, 1'b1);
        send(32'hBF800000, 1'b0, 32'h0000_0000, 1'b1);
        send(32'hBF000000, 1'b0, 32'h0000_0000, 1'b0);
        send(32'h00000000, 1'b1, 32'h0000_0000, 1'b0);
        send(32'h80000001, 1'b1, 32'h0000_0000, 1'b0);
        send(32'h4F800000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send(32'hCF000001, 1'b1, 32'h8000_0000, 1'b1);
        send(32'h7F7FFFFF, 1'b1, 32'h7FFF_FFFF, 1'b1);
        drain();

        // Backpressure: four offers with the consumer holding off.
        yumi_mode = 2;
        tick();
        tick();
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            a        = 32'h41000000 + (i << 20);
            a_i      = a;
            signed_i = 1'b1;
            v_i      = 1'b1;
            @(negedge clk);
            if (ready_o) begin
                acc++;
                begin
                    logic [31:0] z;
                    logic        inv;
                    model(a, 1'b1, z, inv);
                    sb.push_back('{a, 1'b1, z, inv});
                end
            end
            tick();
        end
        v_i = 1'b0;
        check("stall_accepted_count", acc, 32'd2);
        @(negedge clk);
        check("stall_ready_o", 32'(ready_o), 32'd0);
        tick();
        yumi_mode = 0;
        drain();

        // Reset with two results in flight: neither may ever appear.
        yumi_mode = 2;
        tick();
        tick();
        send_model(32'h42280000, 1'b1);
        send_model(32'hC2280000, 1'b1);
        v_i     = 1'b0;
        reset_i = 1'b1;
        sb.delete();
        tick();
        reset_i = 1'b0;
        check("midreset_v_o", 32'(v_o), 32'd0);
        check("midreset_z_o", z_o, 32'd0);
        check("midreset_invalid_o", 32'(invalid_o), 32'd0);
        check("midreset_ready_o", 32'(ready_o), 32'd1);
        yumi_mode = 0;
        repeat (10) tick();

        // Random traffic with random consumer backpressure and input gaps.
        yumi_mode = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 1) a = $urandom();
            else a = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 165)), 23'($urandom())};
            send_model(a, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                v_i = 1'b0;
                tick();
            end
        end
        yumi_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
